// File: rtl/pe_result_drain.sv
// pe_result_drain: captures a vector of N wide PE results into a shadow
// register and streams them out one element per handshake, requantized
// to BW bits with round-half-up and saturation.
module pe_result_drain #(
    parameter int BW    = 8,
    parameter int N     = 4,
    parameter int SHIFT = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_capture,
    input  logic [N*2*BW-1:0]     i_results,
    output logic                  o_busy,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [BW-1:0]         o_out_data,
    output logic [$clog2(N)-1:0]  o_out_index,
    output logic                  o_out_last,
    output logic                  o_dropped,
    output logic [7:0]            o_sat_count
);

    localparam int DW = 2 * BW;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    // Half of one output LSB, or zero when there is no shift at all.
    localparam logic [DW:0] ROUND = ((DW + 1)'(1) << SHIFT) >> 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N*DW-1:0]     shadow_q, shadow_d;
    logic                dropped_q, dropped_d;
    logic [7:0]          satCnt_q, satCnt_d;

    logic [DW-1:0]       elemSel;
    logic [DW:0]         rounded;
    logic [DW:0]         shifted;
    logic                isSat;
    logic [BW-1:0]       quantData;
    logic                busy;
    logic                isLast;
    logic                handshake;

    // Pick the shadow element addressed by the current index.
    always_comb begin
        elemSel = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) begin
                elemSel = shadow_q[k*DW +: DW];
            end
        end
    end

    // Requantize: round, shift, then clip anything that does not fit in BW bits.
    always_comb begin
        rounded   = {1'b0, elemSel} + ROUND;
        shifted   = rounded >> SHIFT;
        isSat     = |shifted[DW:BW];
        quantData = isSat ? {BW{1'b1}} : shifted[BW-1:0];
    end

    assign busy      = (state_q == DRAIN);
    assign isLast    = busy && (idx_q == LAST_IDX);
    assign handshake = busy && i_out_ready;

    // Next-state logic for the drain FSM, index, shadow and status flags.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        dropped_d = dropped_q;
        satCnt_d  = satCnt_q;

        if (handshake && isSat && (satCnt_q != 8'hFF)) begin
            satCnt_d = satCnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (i_capture) begin
                    shadow_d = i_results;
                    idx_d    = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && isLast) begin
                    idx_d = '0;
                    if (i_capture) begin
                        shadow_d = i_results;
                        state_d  = DRAIN;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        idx_d = idx_q + IW'(1);
                    end
                    if (i_capture) begin
                        dropped_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            dropped_q <= 1'b0;
            satCnt_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            dropped_q <= dropped_d;
            satCnt_q  <= satCnt_d;
        end
    end

    assign o_busy      = busy;
    assign o_out_valid = busy;
    assign o_out_data  = busy ? quantData : '0;
    assign o_out_index = idx_q;
    assign o_out_last  = isLast;
    assign o_dropped   = dropped_q;
    assign o_sat_count = satCnt_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// tb_pe_result_drain: directed, table-driven bench for pe_result_drain
// with BW=8, N=4, SHIFT=4, plus hand-written multi-cycle sequences.
module tb_pe_result_drain;

    localparam int BW    = 8;
    localparam int N     = 4;
    localparam int SHIFT = 4;

    localparam logic [63:0] RES_A   = 64'h0008_0FFF_0007_0018;
    localparam logic [63:0] RES_FF  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] RES_16  = 64'h0010_0010_0010_0010;

    logic        clock = 1'b0;
    logic        reset;
    logic        capture;
    logic        ready;
    logic [63:0] results;
    logic        busy;
    logic        outValid;
    logic [7:0]  outData;
    logic [1:0]  outIndex;
    logic        outLast;
    logic        dropped;
    logic [7:0]  satCount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        cap;
        logic        rdy;
        logic [63:0] res;
        logic        expValid;
        logic [7:0]  expData;
        logic [1:0]  expIdx;
        logic        expLast;
        logic [7:0]  expSat;
    } vec_t;

    vec_t vecs[14];

    pe_result_drain #(.BW(BW), .N(N), .SHIFT(SHIFT)) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_capture   (capture),
        .i_results   (results),
        .o_busy      (busy),
        .o_out_valid (outValid),
        .i_out_ready (ready),
        .o_out_data  (outData),
        .o_out_index (outIndex),
        .o_out_last  (outLast),
        .o_dropped   (dropped),
        .o_sat_count (satCount)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive inputs just after a falling edge and let outputs settle.
    task automatic applyStimulus(input logic c, input logic r, input logic [63:0] rs);
        @(negedge clock);
        capture = c;
        ready   = r;
        results = rs;
        #1;
    endtask

    // Check a valid beat: data, index and last flag.
    task automatic checkBeat(input string nm, input logic [7:0] d, input logic [1:0] i, input logic l);
        checkOutput({nm, "_valid"}, 32'(outValid), 32'd1);
        checkOutput({nm, "_data"},  32'(outData),  32'(d));
        checkOutput({nm, "_index"}, 32'(outIndex), 32'(i));
        checkOutput({nm, "_last"},  32'(outLast),  32'(l));
    endtask

    function automatic vec_t mk(input logic c, input logic r, input logic [63:0] rs,
                                input logic v, input logic [7:0] d, input logic [1:0] i,
                                input logic l, input logic [7:0] s);
        vec_t t;
        t.cap = c; t.rdy = r; t.res = rs;
        t.expValid = v; t.expData = d; t.expIdx = i; t.expLast = l; t.expSat = s;
        return t;
    endfunction

    initial begin
        logic [7:0] prevSat;
        logic       wrapped;

        // Full-speed drain, then the same capture with a stuttering consumer.
        vecs[0]  = mk(1, 0, RES_A, 0, 8'h00, 2'd0, 0, 8'd0);
        vecs[1]  = mk(0, 1, RES_A, 1, 8'h02, 2'd0, 0, 8'd0);
        vecs[2]  = mk(0, 1, RES_A, 1, 8'h00, 2'd1, 0, 8'd0);
        vecs[3]  = mk(0, 1, RES_A, 1, 8'hFF, 2'd2, 0, 8'd0);
        vecs[4]  = mk(0, 1, RES_A, 1, 8'h01, 2'd3, 1, 8'd1);
        vecs[5]  = mk(1, 0, RES_A, 0, 8'h00, 2'd0, 0, 8'd1);
        vecs[6]  = mk(0, 1, RES_A, 1, 8'h02, 2'd0, 0, 8'd1);
        vecs[7]  = mk(0, 0, RES_A, 1, 8'h00, 2'd1, 0, 8'd1);
        vecs[8]  = mk(0, 0, RES_A, 1, 8'h00, 2'd1, 0, 8'd1);
        vecs[9]  = mk(0, 1, RES_A, 1, 8'h00, 2'd1, 0, 8'd1);
        vecs[10] = mk(0, 1, RES_A, 1, 8'hFF, 2'd2, 0, 8'd1);
        vecs[11] = mk(0, 0, RES_A, 1, 8'h01, 2'd3, 1, 8'd2);
        vecs[12] = mk(0, 1, RES_A, 1, 8'h01, 2'd3, 1, 8'd2);
        vecs[13] = mk(0, 0, RES_A, 0, 8'h00, 2'd0, 0, 8'd2);

        reset = 1'b1; capture = 1'b0; ready = 1'b0; results = '0;
        #1;
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_busy",  32'(busy),     32'd0);
        checkOutput("rst_data",  32'(outData),  32'd0);
        checkOutput("rst_index", 32'(outIndex), 32'd0);
        checkOutput("rst_last",  32'(outLast),  32'd0);
        checkOutput("rst_drop",  32'(dropped),  32'd0);
        checkOutput("rst_sat",   32'(satCount), 32'd0);
        #12;
        @(negedge clock);
        reset = 1'b0;

        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].cap, vecs[v].rdy, vecs[v].res);
            checkOutput($sformatf("v%0d_valid", v), 32'(outValid), 32'(vecs[v].expValid));
            checkOutput($sformatf("v%0d_busy", v),  32'(busy),     32'(vecs[v].expValid));
            checkOutput($sformatf("v%0d_sat", v),   32'(satCount), 32'(vecs[v].expSat));
            checkOutput($sformatf("v%0d_drop", v),  32'(dropped),  32'd0);
            if (vecs[v].expValid) begin
                checkOutput($sformatf("v%0d_data", v),  32'(outData),  32'(vecs[v].expData));
                checkOutput($sformatf("v%0d_index", v), 32'(outIndex), 32'(vecs[v].expIdx));
                checkOutput($sformatf("v%0d_last", v),  32'(outLast),  32'(vecs[v].expLast));
            end
        end

        // Capture during beat 1 is dropped and leaves the shadow data intact.
        applyStimulus(1, 0, RES_A);
        applyStimulus(0, 1, RES_A);
        checkBeat("drop_b0", 8'h02, 2'd0, 0);
        applyStimulus(1, 1, RES_FF);
        checkBeat("drop_b1", 8'h00, 2'd1, 0);
        checkOutput("drop_pre", 32'(dropped), 32'd0);
        applyStimulus(0, 0, RES_A);
        checkOutput("drop_set", 32'(dropped), 32'd1);
        checkBeat("drop_hold", 8'hFF, 2'd2, 0);
        applyStimulus(0, 1, RES_A);
        checkBeat("drop_b2", 8'hFF, 2'd2, 0);
        applyStimulus(0, 1, RES_A);
        checkBeat("drop_b3", 8'h01, 2'd3, 1);
        applyStimulus(0, 0, RES_A);
        checkOutput("drop_idle", 32'(outValid), 32'd0);
        checkOutput("drop_sticky", 32'(dropped), 32'd1);
        checkOutput("drop_sat", 32'(satCount), 32'd3);

        // Capture on the last handshake chains straight into a new drain.
        applyStimulus(1, 0, RES_A);
        applyStimulus(0, 1, RES_A);
        applyStimulus(0, 1, RES_A);
        applyStimulus(0, 1, RES_A);
        applyStimulus(1, 1, RES_16);
        checkBeat("chain_last", 8'h01, 2'd3, 1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(0, 1, RES_A);
            checkBeat($sformatf("chain_b%0d", b), 8'h01, 2'(b), (b == 3));
        end
        applyStimulus(0, 0, RES_A);
        checkOutput("chain_idle", 32'(outValid), 32'd0);
        checkOutput("chain_drop", 32'(dropped), 32'd1);
        checkOutput("chain_sat", 32'(satCount), 32'd4);

        // Asynchronous reset in the middle of a drain, then a fresh start.
        applyStimulus(1, 0, RES_A);
        applyStimulus(0, 1, RES_A);
        applyStimulus(0, 1, RES_A);
        applyStimulus(0, 0, RES_A);
        checkBeat("ar_pre", 8'hFF, 2'd2, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_valid", 32'(outValid), 32'd0);
        checkOutput("ar_busy",  32'(busy),     32'd0);
        checkOutput("ar_data",  32'(outData),  32'd0);
        checkOutput("ar_index", 32'(outIndex), 32'd0);
        checkOutput("ar_last",  32'(outLast),  32'd0);
        checkOutput("ar_drop",  32'(dropped),  32'd0);
        checkOutput("ar_sat",   32'(satCount), 32'd0);
        applyStimulus(1, 1, RES_A);
        checkOutput("ar_held", 32'(outValid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        capture = 1'b0;
        applyStimulus(0, 0, RES_A);
        checkOutput("ar_idle", 32'(outValid), 32'd0);
        applyStimulus(1, 0, RES_A);
        applyStimulus(0, 1, RES_A);
        checkBeat("ar_restart", 8'h02, 2'd0, 0);
        applyStimulus(0, 1, RES_A);
        applyStimulus(0, 1, RES_A);
        applyStimulus(0, 1, RES_A);
        applyStimulus(0, 0, RES_A);
        checkOutput("ar_done", 32'(outValid), 32'd0);

        // Saturation counter hits 255 and stays there across many drains.
        @(negedge clock);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        prevSat = 8'd0;
        wrapped = 1'b0;
        for (int d = 0; d < 300; d++) begin
            applyStimulus(1, 0, RES_FF);
            if (d == 63) checkOutput("sat_252", 32'(satCount), 32'd252);
            if (d == 64) checkOutput("sat_255", 32'(satCount), 32'd255);
            for (int b = 0; b < 4; b++) begin
                applyStimulus(0, 1, RES_FF);
                if (satCount < prevSat) wrapped = 1'b1;
                prevSat = satCount;
            end
        end
        applyStimulus(0, 0, RES_FF);
        checkOutput("sat_final", 32'(satCount), 32'd255);
        checkOutput("sat_nowrap", 32'(wrapped), 32'd0);
        checkOutput("sat_idle", 32'(outValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_result_drain.md
PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

Interface
REQ-001 SHALL have parameter BW, default 8, meaning PE operand width; PE results are 2*BW bits.
REQ-002 SHALL have parameter N, default 4, meaning the number of PE results captured per drain; N >= 2.
REQ-003 SHALL have parameter SHIFT, default 4, meaning the requantization right-shift; 0 <= SHIFT < 2*BW.
REQ-004 SHALL have port i_clock, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-006 SHALL have port i_capture, input, 1 bit, meaning a request to latch i_results this cycle.
REQ-007 SHALL have port i_results, input, N*2*BW bits, meaning unsigned PE outputs; element k occupies bits [(k+1)*2*BW-1 : k*2*BW].
REQ-008 SHALL have port o_busy, output, 1 bit, meaning the block is in DRAIN.
REQ-009 SHALL have port o_out_valid, output, 1 bit, meaning o_out_data, o_out_index and o_out_last are valid.
REQ-010 SHALL have port i_out_ready, input, 1 bit, meaning the consumer accepts the current element.
REQ-011 SHALL have port o_out_data, output, BW bits, meaning the requantized element.
REQ-012 SHALL have port o_out_index, output, $clog2(N) bits, meaning the element index k.
REQ-013 SHALL have port o_out_last, output, 1 bit, meaning the current element is k = N-1.
REQ-014 SHALL have port o_dropped, output, 1 bit, meaning a sticky flag set when a capture was ignored.
REQ-015 SHALL have port o_sat_count, output, 8 bits, meaning a saturating count of clipped elements.

Function
REQ-016 SHALL implement the states IDLE and DRAIN; o_busy = o_out_valid = (state == DRAIN).
REQ-017 In IDLE, i_capture=1 SHALL latch all N elements into a shadow register, set the index to 0, and enter DRAIN on the same edge.
REQ-018 Latency SHALL be one cycle: a capture at edge t gives o_out_valid=1 with element 0 in the cycle after t.
REQ-019 o_out_data SHALL be computed from the shadow element at the index as r = (x + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, with 2*BW+1-bit intermediate width, so the rounding addition never wraps.
REQ-020 If r > 2^BW-1, o_out_data SHALL be 2^BW-1 (saturation); otherwise o_out_data = r[BW-1:0].
REQ-021 On each handshake (o_out_valid & i_out_ready) of a saturated element, o_sat_count SHALL increment, holding at 255.
REQ-022 A handshake with o_out_last=0 SHALL increment the index; with i_out_ready=0, all outputs SHALL hold stable.
REQ-023 A handshake with o_out_last=1 SHALL return to IDLE unless i_capture=1 in the same cycle; in that case the block SHALL latch new results, set the index to 0 and stay in DRAIN with no gap cycle.
REQ-024 i_capture=1 in DRAIN, other than the case in REQ-023, SHALL be ignored: the shadow register is unchanged and o_dropped is set to 1.
REQ-025 The shadow register SHALL change only on an accepted capture.

Reset
REQ-026 i_reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, index=0, shadow=0, o_dropped=0 and o_sat_count=0; therefore o_busy=0, o_out_valid=0, o_out_data=0, o_out_index=0 and o_out_last=0.
REQ-027 Reset during DRAIN SHALL abandon the remaining elements; after release, the first edge with i_capture=1 SHALL start a fresh drain at element 0.

Verification (BW=8, N=4, SHIFT=4)
REQ-028 Capture {k0..k3} = {0x0018, 0x0007, 0x0FFF, 0x0008} with ready=1 -> four consecutive beats with data 0x02, 0x00, 0xFF, 0x01, index 0..3, last on beat 3, o_sat_count=1, then o_busy=0.
REQ-029 Same capture, with ready toggling 1,0,0,1,1,0,1 -> each element is held stable while ready=0, the same four values are delivered in order, and no beat is duplicated or skipped.
REQ-030 i_capture pulsed during beat 1 -> o_dropped=1, the remaining beats still carry the original data, and o_dropped stays 1 until reset.
REQ-031 i_capture held 1 on the last handshake with new results {0x0010 x4} -> the next cycle shows index 0, data 0x01, o_out_valid continuously 1.
REQ-032 i_reset asserted mid-drain at index 2 (between edges) -> o_out_valid=0, o_sat_count=0 and o_dropped=0 immediately; a later capture restarts at index 0.
REQ-033 300 captures of {0xFFFF x4} drained -> o_sat_count saturates at 255 and never wraps to 0.
